// File: rtl/std_div_stream_issue.sv
`timescale 1ns/1ps
// std_div_stream_issue
//
// Stream front end for a multi-cycle go/done arithmetic unit (divider,
// modulus, sqrt-style sequential primitive). Operand pairs arrive on a
// valid/ready stream and are buffered in a small FIFO. They are issued one
// at a time to the attached unit. The result is captured into a one-entry
// output register and presented on a valid/ready result stream.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high. Valid does not depend on ready.
// in_ready does not depend on in_valid. A presented result (out_valid,
// out_data) stays unchanged until it is taken.
//
// Optional feature (macro DIV_ZERO_BYPASS_EN):
//   When defined, a head entry whose divisor is zero is not sent to the
//   unit. It is popped in IDLE, and all-ones is produced as its result on
//   the next cycle. When undefined, zero divisors go to the unit like any
//   other operand.
//
// Parameters
//   width      operand and result width
//   DEPTH      operand FIFO entries (power of two, >= 2)
//
// Ports
//   clk        clock, all logic on rising edge
//   reset      synchronous, active-low reset
//   in_valid   operand pair valid
//   in_ready   FIFO can accept (count < DEPTH)
//   in_left    dividend / first operand
//   in_right   divisor / second operand
//   out_valid  result register holds a result
//   out_ready  consumer accepts result
//   out_data   result
//   unit_go    go to attached unit (registered, held until done)
//   unit_left  operand to unit (registered)
//   unit_right operand to unit (registered)
//   unit_out   unit result
//   unit_done  unit completion strobe (only honoured in BUSY)
//   busy       state != IDLE or FIFO non-empty
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RECOVER)

module std_div_stream_issue #(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_left,
  input  logic [width-1:0] in_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             unit_go,
  output logic [width-1:0] unit_left,
  output logic [width-1:0] unit_right,
  input  logic [width-1:0] unit_out,
  input  logic             unit_done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t state;

  // Operand FIFO storage and bookkeeping.
  logic [width-1:0] fifo_left  [DEPTH];
  logic [width-1:0] fifo_right [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic push;
  logic pop;
  logic can_issue;
  logic issue;

  // The head may leave the FIFO only in IDLE with no result outstanding.
  // That single rule gives in-order delivery and at most one result in
  // flight.
  assign can_issue = (state == S_IDLE) && (count != '0) && !out_valid;

`ifdef DIV_ZERO_BYPASS_EN
  logic head_zero;
  logic bypass;

  assign head_zero = (fifo_right[rd_ptr] == '0);
  assign bypass    = can_issue && head_zero;
  assign issue     = can_issue && !head_zero;
`else
  assign issue     = can_issue;
`endif

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A zero-divisor bypass also consumes the head, so every can_issue pops.
  assign pop      = can_issue;

  assign busy      = (state != S_IDLE) || (count != '0);
  assign dbg_state = state;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_left[wr_ptr]  <= in_left;
      fifo_right[wr_ptr] <= in_right;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered unit and result outputs.
  // RECOVER keeps unit_go low for one full cycle so the unit can re-arm
  // before the next operation is issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      unit_go    <= 1'b0;
      unit_left  <= '0;
      unit_right <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      // Consumer takes the result. The FSM only sets out_valid while it is
      // low, so this never collides with a new capture.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (issue) begin
            unit_left  <= fifo_left[rd_ptr];
            unit_right <= fifo_right[rd_ptr];
            unit_go    <= 1'b1;
            state      <= S_BUSY;
          end
`ifdef DIV_ZERO_BYPASS_EN
          else if (bypass) begin
            out_data  <= {width{1'b1}};
            out_valid <= 1'b1;
          end
`endif
        end

        S_BUSY: begin
          // go and operands stay put until the unit signals completion.
          if (unit_done) begin
            out_data  <= unit_out;
            out_valid <= 1'b1;
            unit_go   <= 1'b0;
            state     <= S_RECOVER;
          end
        end

        S_RECOVER: begin
          state <= S_IDLE;
        end

        default: begin
          unit_go <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_div_stream_issue.sv
`timescale 1ns/1ps
module tb_std_div_stream_issue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  // Value the modelled unit returns for a zero divisor.
  localparam logic [W-1:0] DIV0_RES = 32'h5A5A_5A5A;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_left = '0;
  logic [W-1:0] in_right = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         unit_go;
  logic [W-1:0] unit_left;
  logic [W-1:0] unit_right;
  logic [W-1:0] unit_out = '0;
  logic         unit_done;
  logic         busy;
  logic [1:0]   dbg_state;

  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  assign unit_done = model_done | spur_done;

  always #5 clk = ~clk;

  std_div_stream_issue #(.width(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .unit_go(unit_go), .unit_left(unit_left), .unit_right(unit_right),
    .unit_out(unit_out), .unit_done(unit_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] iss_q[$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain division, zero divisor handled by the feature rule.
  function automatic logic [W-1:0] expect_of(input logic [W-1:0] l, input logic [W-1:0] r);
    if (r == '0) begin
`ifdef DIV_ZERO_BYPASS_EN
      return {W{1'b1}};
`else
      return DIV0_RES;
`endif
    end
    return l / r;
  endfunction

  function automatic bit goes_to_unit(input logic [W-1:0] r);
`ifdef DIV_ZERO_BYPASS_EN
    return (r != '0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic note_push(input logic [W-1:0] l, input logic [W-1:0] r);
    exp_q.push_back(expect_of(l, r));
    if (goes_to_unit(r)) iss_q.push_back({l, r});
  endtask

  // ---------------- attached unit model ----------------
  int lat = 8;
  bit rand_lat = 1'b0;
  bit model_abort = 1'b0;
  bit m_running = 1'b0;
  bit m_armed = 1'b1;
  int m_cnt = 0;
  logic [W-1:0] m_l = '0;
  logic [W-1:0] m_r = '0;

  // Starts on go (only after having seen go low), answers after a latency,
  // then waits for go to drop before accepting another operation.
  initial begin : unit_model
    forever begin
      @(posedge clk); #2;
      model_done = 1'b0;
      if (model_abort) begin
        m_running   = 1'b0;
        m_armed     = 1'b0;
        model_abort = 1'b0;
      end else if (m_running) begin
        if (m_cnt == 0) begin
          model_done = 1'b1;
          unit_out   = (m_r == '0) ? DIV0_RES : (m_l / m_r);
          m_running  = 1'b0;
          m_armed    = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (unit_go && m_armed) begin
        m_running = 1'b1;
        m_l       = unit_left;
        m_r       = unit_right;
        m_cnt     = (rand_lat ? int'($urandom_range(1, 10)) : lat) - 1;
      end
      if (!unit_go) m_armed = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit           mon_en = 1'b0;
  bit           p_go = 1'b0, p_acc = 1'b0, p_ov = 1'b0, p_ordy = 1'b0;
  logic [W-1:0] p_l = '0, p_r = '0, p_d = '0;
  logic [2*W-1:0] iss_head;

  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (p_acc) begin
        check_eq("go_low_after_done", unit_go, 0);
        check_eq("out_valid_after_done", out_valid, 1);
      end
      if (unit_go && !p_go) begin
        check_eq("no_issue_with_result_pending", out_valid, 0);
        check_eq("issue_was_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          iss_head = iss_q.pop_front();
          check_eq("issue_left", unit_left, iss_head[2*W-1:W]);
          check_eq("issue_right", unit_right, iss_head[W-1:0]);
        end
      end
      if (unit_go && p_go) begin
        check_eq("operands_held", {unit_left, unit_right}, {p_l, p_r});
      end
      if (p_ov && !p_ordy) begin
        check_eq("out_valid_held", out_valid, 1);
        check_eq("out_data_stable", out_data, p_d);
      end
      if (out_valid && out_ready) begin
        check_eq("result_was_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("out_data", out_data, exp_q.pop_front());
      end
      p_go   = unit_go;
      p_acc  = unit_go && unit_done;
      p_l    = unit_left;
      p_r    = unit_right;
      p_ov   = out_valid;
      p_ordy = out_ready;
      p_d    = out_data;
    end else begin
      p_go = 1'b0; p_acc = 1'b0; p_ov = 1'b0; p_ordy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_left = l; in_right = r;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    check_eq("push_accepted", acc, 1);
    if (acc) note_push(l, r);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 2000) begin
      tick();
      n++;
    end
    check_eq(name, exp_q.size(), 0);
    check_eq("idle_after_drain", busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  bit rnd_on = 1'b0;

  initial begin
    int acc_n;
    bit seen;
    int n;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_unit_go", unit_go, 0);
    check_eq("rst_unit_left", unit_left, 0);
    check_eq("rst_unit_right", unit_right, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, 0);
    tick();
    reset = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single op: 100/7, go two cycles after the push cycle
    out_ready = 1'b1;
    lat = 8;
    offer(100, 7);
    @(negedge clk);
    check_eq("single_go_not_yet", unit_go, 0);
    @(negedge clk);
    check_eq("single_go", unit_go, 1);
    check_eq("single_left", unit_left, 100);
    check_eq("single_right", unit_right, 7);
    tick();
    wait_drain("single_drain");

    // Fill with consumer stalled: 1 issued + DEPTH queued
    out_ready = 1'b0;
    acc_n = 0;
    in_valid = 1'b1; in_left = 100; in_right = 7;
    for (int i = 0; i < 12; i++) begin
      bit a;
      a = in_ready;
      tick();
      if (a) begin
        note_push(in_left, in_right);
        acc_n++;
        in_left  = $urandom;
        in_right = $urandom_range(1, 50);
      end
    end
    in_valid = 1'b0;
    check_eq("fill_accepted", acc_n, DEPTH + 1);
    check_eq("fill_in_ready_low", in_ready, 0);

    // Back-pressure on the first result (14)
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check_eq("bp_result_present", out_valid, 1);
    check_eq("bp_data", out_data, 14);
    repeat (10) tick();
    check_eq("bp_still_valid", out_valid, 1);
    check_eq("bp_no_second_go", unit_go, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (unit_go) seen = 1'b1;
    end
    check_eq("bp_next_go_by_h2", seen, 1);
    tick();
    out_ready = 1'b1;
    wait_drain("fill_drain");

    // Ordering
    offer(50, 5);
    offer(81, 9);
    offer(7, 8);
    wait_drain("order_drain");

    // Reset mid-BUSY with two entries queued
    lat = 20;
    offer(1000, 3);
    offer(55, 5);
    offer(9, 2);
    check_eq("rstb_go_before", unit_go, 1);
    reset = 1'b0;
    model_abort = 1'b1;
    exp_q.delete();
    iss_q.delete();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstb_unit_go", unit_go, 0);
    check_eq("rstb_out_valid", out_valid, 0);
    check_eq("rstb_in_ready", in_ready, 1);
    check_eq("rstb_busy", busy, 0);
    repeat (30) tick();
    check_eq("rstb_no_result", out_valid, 0);
    check_eq("rstb_still_idle", busy, 0);
    lat = 8;

    // Zero divisor
    out_ready = 1'b0;
    offer(9, 0);
    @(negedge clk);
    check_eq("zero_cycle1_no_result", out_valid, 0);
    @(negedge clk);
`ifdef DIV_ZERO_BYPASS_EN
    check_eq("zero_bypass_valid", out_valid, 1);
    check_eq("zero_bypass_data", out_data, 32'hFFFF_FFFF);
    check_eq("zero_bypass_no_go", unit_go, 0);
    repeat (3) begin
      @(negedge clk);
      check_eq("zero_bypass_no_go_later", unit_go, 0);
    end
`else
    check_eq("zero_go", unit_go, 1);
    check_eq("zero_right", unit_right, 0);
    check_eq("zero_left", unit_left, 9);
`endif
    tick();
    out_ready = 1'b1;
    wait_drain("zero_drain");

    // Spurious done while idle
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("spurious_done_no_valid", out_valid, 0);
      check_eq("spurious_done_no_go", unit_go, 0);
    end
    tick();

    // Randomised traffic with random consumer stalls
    rand_lat = 1'b1;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] l, r;
      repeat ($urandom_range(0, 2)) tick();
      l = $urandom;
      case ($urandom_range(0, 7))
        0:       r = '0;
        1:       r = $urandom;
        default: r = $urandom_range(1, 1000);
      endcase
      offer(l, r);
    end
    rnd_on = 1'b0;
    tick();
    #1;
    out_ready = 1'b1;
    tick();
    wait_drain("random_drain");
    check_eq("all_issues_seen", iss_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
